// File: rtl/zbt_frame_writer.sv
// rtl/zbt_frame_writer.sv - buffered sequential writer of packed 36-bit pixel words into ZBT SRAM
//
// Purpose:
//   Accepts one packed pixel word per new_input strobe, queues it in a small
//   FIFO and writes it to ZBT SRAM at sequential addresses starting at
//   BASE_ADDR whenever the memory arbiter grants a write slot. frame_done
//   pulses with the last write of a frame.
//
// Ports:
//   clk             system clock
//   reset           asynchronous, active-high
//   frame_start     1-cycle pulse: flush FIFO, restart address at BASE_ADDR, arm
//   new_input       1-cycle strobe qualifying word_in
//   word_in         packed pixel word
//   mem_grant       high: the next cycle is a write slot for this block
//   mem_we          write strobe, one cycle per word
//   mem_addr        write address (holds when mem_we=0)
//   mem_write_data  write data (holds when mem_we=0)
//   frame_done      1-cycle pulse coincident with the last write of a frame
//   overflow        sticky: a word was dropped on a full FIFO
//   fifo_level      current FIFO occupancy
//   busy            high while a frame is being written
module zbt_frame_writer #(
  parameter int ADDR_WIDTH  = 19,
  parameter int BASE_ADDR   = 0,
  parameter int FRAME_WORDS = 19200,
  parameter int FIFO_DEPTH  = 4,
  parameter int CONTINUOUS  = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          frame_start,
  input  logic                          new_input,
  input  logic [35:0]                   word_in,
  input  logic                          mem_grant,
  output logic                          mem_we,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [35:0]                   mem_write_data,
  output logic                          frame_done,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = $clog2(FRAME_WORDS);
  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [CW-1:0]         LAST_CNT = CW'(FRAME_WORDS - 1);
  localparam logic [LW-1:0]         FULL_LVL = LW'(FIFO_DEPTH);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                  state_q, state_d;
  logic [35:0]             fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]           rd_ptr, wr_ptr, wr_idx;
  logic [LW-1:0]           level;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [CW-1:0]           count;

  logic active, fifo_empty, fifo_full;
  logic push_req, push, pop, drop, last_word;

  assign active     = (state_q == ACTIVE);
  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == FULL_LVL);

  // frame_start blocks the pop so the flushed FIFO and restarted address
  // never race with an issue from the abandoned frame.
  assign pop       = active && !fifo_empty && mem_grant && !frame_start;
  assign push_req  = new_input && (active || frame_start);
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign push      = frame_start ? new_input : (push_req && (!fifo_full || pop));
  assign drop      = !frame_start && push_req && fifo_full && !pop;
  assign last_word = pop && (count == LAST_CNT);
  // The word arriving with frame_start lands in slot 0 of the flushed FIFO.
  assign wr_idx    = frame_start ? '0 : wr_ptr;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_start) state_d = ACTIVE;
      ACTIVE: begin
        if (frame_start)                        state_d = ACTIVE;
        else if (last_word && CONTINUOUS == 0)  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    busy = 1'b0;
    if (state_q == ACTIVE) busy = 1'b1;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else if (frame_start) begin
      rd_ptr <= '0;
      wr_ptr <= PW'(new_input);
      level  <= LW'(new_input);
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      level <= level + LW'(1);
      else if (pop && !push) level <= level - LW'(1);
    end
  end

  // FIFO storage; contents are qualified by the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_idx] <= word_in;
  end

  // Frame address and word counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr  <= BASE;
      count <= '0;
    end else if (frame_start || last_word) begin
      addr  <= BASE;
      count <= '0;
    end else if (pop) begin
      addr  <= addr + ADDR_WIDTH'(1);
      count <= count + CW'(1);
    end
  end

  // Registered memory port and status
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_we         <= 1'b0;
      mem_addr       <= BASE;
      mem_write_data <= '0;
      frame_done     <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      mem_we     <= pop;
      frame_done <= last_word;
      if (pop) begin
        mem_addr       <= addr;
        mem_write_data <= fifo_mem[rd_ptr];
      end
      if (frame_start) overflow <= 1'b0;
      else if (drop)   overflow <= 1'b1;
    end
  end

  assign fifo_level = level;

endmodule

// File: tb/tb_zbt_frame_writer.sv
// tb/tb_zbt_frame_writer.sv - directed self-checking bench for zbt_frame_writer
module tb_zbt_frame_writer;

  typedef struct {
    logic [18:0] addr;
    logic [35:0] data;
    logic        done;
    int          cyc;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start;
  logic        new_input;
  logic [35:0] word_in;
  logic        mem_grant;

  logic        a_mem_we, a_frame_done, a_overflow, a_busy;
  logic [18:0] a_mem_addr;
  logic [35:0] a_mem_write_data;
  logic [2:0]  a_fifo_level;

  logic        b_mem_we, b_frame_done, b_overflow, b_busy;
  logic [18:0] b_mem_addr;
  logic [35:0] b_mem_write_data;
  logic [2:0]  b_fifo_level;

  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  int  done_a   = 0;
  int  done_b   = 0;
  int  first_cyc;
  wr_t log_a[$];
  wr_t log_b[$];

  zbt_frame_writer #(.ADDR_WIDTH(19), .BASE_ADDR(0), .FRAME_WORDS(8),
                     .FIFO_DEPTH(4), .CONTINUOUS(0)) u_a (
    .clk(clk), .reset(reset), .frame_start(frame_start), .new_input(new_input),
    .word_in(word_in), .mem_grant(mem_grant), .mem_we(a_mem_we),
    .mem_addr(a_mem_addr), .mem_write_data(a_mem_write_data),
    .frame_done(a_frame_done), .overflow(a_overflow),
    .fifo_level(a_fifo_level), .busy(a_busy)
  );

  zbt_frame_writer #(.ADDR_WIDTH(19), .BASE_ADDR(0), .FRAME_WORDS(4),
                     .FIFO_DEPTH(4), .CONTINUOUS(1)) u_b (
    .clk(clk), .reset(reset), .frame_start(frame_start), .new_input(new_input),
    .word_in(word_in), .mem_grant(mem_grant), .mem_we(b_mem_we),
    .mem_addr(b_mem_addr), .mem_write_data(b_mem_write_data),
    .frame_done(b_frame_done), .overflow(b_overflow),
    .fifo_level(b_fifo_level), .busy(b_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Write monitor, sampled 2 time units after the active edge.
  always @(posedge clk) begin
    wr_t e;
    #2;
    if (a_mem_we) begin
      e.addr = a_mem_addr; e.data = a_mem_write_data; e.done = a_frame_done; e.cyc = cyc;
      log_a.push_back(e);
    end
    if (a_frame_done) done_a++;
    if (b_mem_we) begin
      e.addr = b_mem_addr; e.data = b_mem_write_data; e.done = b_frame_done; e.cyc = cyc;
      log_b.push_back(e);
    end
    if (b_frame_done) done_b++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input logic [35:0] w);
    new_input = 1'b1;
    word_in   = w;
    tick(1);
    new_input = 1'b0;
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(1);
  endtask

  initial begin
    reset = 1'b1; frame_start = 1'b0; new_input = 1'b0; word_in = '0; mem_grant = 1'b0;
    tick(2);

    // Reset state
    check("rst_we",    {63'd0, a_mem_we},     64'd0);
    check("rst_done",  {63'd0, a_frame_done}, 64'd0);
    check("rst_ovf",   {63'd0, a_overflow},   64'd0);
    check("rst_level", {61'd0, a_fifo_level}, 64'd0);
    check("rst_busy",  {63'd0, a_busy},       64'd0);
    check("rst_addr",  {45'd0, a_mem_addr},   64'd0);
    check("rst_data",  {28'd0, a_mem_write_data}, 64'd0);
    reset = 1'b0;
    tick(1);

    // 1: four words, grant always on
    mem_grant = 1'b1;
    start_frame();
    check("t1_busy", {63'd0, a_busy}, 64'd1);
    log_a.delete();
    for (int i = 0; i < 4; i++) begin
      strobe(36'hA0 + 36'(i));
      if (i == 0) first_cyc = cyc;
    end
    tick(4);
    check("t1_nwr", 64'(log_a.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t1_addr%0d", i), {45'd0, log_a[i].addr}, 64'(i));
      check($sformatf("t1_data%0d", i), {28'd0, log_a[i].data}, 64'hA0 + 64'(i));
    end
    check("t1_latency", 64'(log_a[0].cyc), 64'(first_cyc + 1));
    check("t1_we_low",  {63'd0, a_mem_we}, 64'd0);
    check("t1_hold_addr", {45'd0, a_mem_addr}, 64'd3);
    check("t1_hold_data", {28'd0, a_mem_write_data}, 64'hA3);

    // 2: complete the 8-word frame, then a stray strobe
    for (int i = 4; i < 8; i++) strobe(36'hA0 + 36'(i));
    tick(4);
    check("t2_nwr",    64'(log_a.size()), 64'd8);
    check("t2_addr7",  {45'd0, log_a[7].addr}, 64'd7);
    check("t2_done7",  {63'd0, log_a[7].done}, 64'd1);
    check("t2_done6",  {63'd0, log_a[6].done}, 64'd0);
    check("t2_ndone",  64'(done_a), 64'd1);
    check("t2_busy",   {63'd0, a_busy}, 64'd0);
    strobe(36'hA8);
    tick(4);
    check("t2_nwr_after", 64'(log_a.size()), 64'd8);

    // 3: grant withheld, six strobes into a 4-deep FIFO
    pulse_reset();
    mem_grant = 1'b0;
    start_frame();
    log_a.delete();
    for (int i = 0; i < 6; i++) strobe(36'h30 + 36'(i));
    check("t3_level", {61'd0, a_fifo_level}, 64'd4);
    check("t3_ovf",   {63'd0, a_overflow},   64'd1);
    check("t3_nwr0",  64'(log_a.size()),     64'd0);
    mem_grant = 1'b1;
    tick(6);
    check("t3_nwr", 64'(log_a.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("t3_data%0d", i), {28'd0, log_a[i].data}, 64'h30 + 64'(i));
    check("t3_level_drained", {61'd0, a_fifo_level}, 64'd0);
    check("t3_ovf_sticky", {63'd0, a_overflow}, 64'd1);
    start_frame();
    check("t3_ovf_clr", {63'd0, a_overflow}, 64'd0);

    // 4: full FIFO, push and pop in the same cycle
    log_a.delete();
    mem_grant = 1'b0;
    for (int i = 0; i < 4; i++) strobe(36'h40 + 36'(i));
    check("t4_level_full", {61'd0, a_fifo_level}, 64'd4);
    mem_grant = 1'b1;
    strobe(36'h44);
    mem_grant = 1'b0;
    check("t4_level", {61'd0, a_fifo_level}, 64'd4);
    check("t4_ovf",   {63'd0, a_overflow},   64'd0);
    mem_grant = 1'b1;
    tick(6);
    check("t4_nwr",   64'(log_a.size()), 64'd5);
    check("t4_data4", {28'd0, log_a[4].data}, 64'h44);
    check("t4_addr4", {45'd0, log_a[4].addr}, 64'd4);

    // 5: restart mid-frame with a word on the frame_start cycle
    pulse_reset();
    done_a = 0;
    mem_grant = 1'b1;
    start_frame();
    log_a.delete();
    for (int i = 0; i < 5; i++) strobe(36'h50 + 36'(i));
    tick(4);
    check("t5_pre_nwr",  64'(log_a.size()), 64'd5);
    check("t5_pre_addr", {45'd0, log_a[4].addr}, 64'd4);
    mem_grant = 1'b0;
    strobe(36'h55);
    strobe(36'h56);
    check("t5_queued", {61'd0, a_fifo_level}, 64'd2);
    log_a.delete();
    mem_grant = 1'b1;
    frame_start = 1'b1; new_input = 1'b1; word_in = 36'h5F;
    tick(1);
    frame_start = 1'b0; new_input = 1'b0;
    check("t5_level_flush", {61'd0, a_fifo_level}, 64'd1);
    tick(4);
    check("t5_nwr",   64'(log_a.size()), 64'd1);
    check("t5_addr",  {45'd0, log_a[0].addr}, 64'd0);
    check("t5_data",  {28'd0, log_a[0].data}, 64'h5F);
    check("t5_ndone", 64'(done_a), 64'd0);
    check("t5_busy",  {63'd0, a_busy}, 64'd1);

    // 6: continuous mode, FRAME_WORDS=4, ten words
    pulse_reset();
    log_b.delete();
    done_b = 0;
    mem_grant = 1'b1;
    start_frame();
    for (int i = 0; i < 10; i++) strobe(36'h60 + 36'(i));
    tick(4);
    check("t6_nwr", 64'(log_b.size()), 64'd10);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("t6_addr%0d", i), {45'd0, log_b[i].addr}, 64'(i % 4));
      check($sformatf("t6_data%0d", i), {28'd0, log_b[i].data}, 64'h60 + 64'(i));
    end
    check("t6_ndone", 64'(done_b), 64'd2);
    check("t6_busy",  {63'd0, b_busy}, 64'd1);
    check("t6_ovf",   {63'd0, b_overflow}, 64'd0);

    // Async reset in the middle of a burst
    new_input = 1'b1; word_in = 36'h70;
    tick(3);
    @(posedge clk);
    #3;
    check("t6_we_pre_rst", {63'd0, b_mem_we}, 64'd1);
    reset = 1'b1;
    #1;
    check("t6_we_rst",    {63'd0, b_mem_we},     64'd0);
    check("t6_busy_rst",  {63'd0, b_busy},       64'd0);
    check("t6_level_rst", {61'd0, b_fifo_level}, 64'd0);
    tick(1);
    reset = 1'b0;
    log_b.delete();
    tick(5);
    new_input = 1'b0;
    tick(2);
    check("t6_nwr_idle", 64'(log_b.size()), 64'd0);
    start_frame();
    strobe(36'h7A);
    tick(4);
    check("t6_nwr_new",  64'(log_b.size()), 64'd1);
    check("t6_addr_new", {45'd0, log_b[0].addr}, 64'd0);
    check("t6_data_new", {28'd0, log_b[0].data}, 64'h7A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
